seg_scan_ctrl: RTL

- Time-multiplexed scan controller for a bank of common-anode seven-segment digits.
- Shares one hex-to-seven-segment decoder across NUM_DIGITS digits by sequencing digit select, per-digit blanking and nibble routing.
- Double-buffers the displayed value so updates land only on frame boundaries, which prevents tearing.
- Sits between the lab datapath (which produces a hex value) and the board display pins.

---
 rtl/seg_scan_ctrl_pkg.sv | 19 +
 rtl/seg_scan_ctrl_hex7seg.sv | 33 +++
 rtl/seg_scan_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: scan state
// encoding, the all-segments-off pattern and counter sizing.
package seg_scan_ctrl_pkg;

    // Scan phase within one digit slot.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    // Active-low segment bus with every segment dark.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Width of a counter that must reach refresh_div-1; never narrower than 1 bit.
    function automatic int cnt_width(input int refresh_div);
        return (refresh_div > 1) ? $clog2(refresh_div) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_hex7seg.sv
// Team hex-to-seven-segment decoder. Active-low outputs, bit0 = a ... bit6 = g.
module seg_scan_ctrl_hex7seg
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Pure lookup from hex digit to active-low segment pattern.
    always_comb begin
        seg_o = SEG_OFF;
        case (nibble_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode seven-segment digits.
// Each digit slot is a short all-dark BLANK phase (ghosting guard) followed
// by a SHOW phase with that digit's anode driven. The displayed value is
// double-buffered and only swaps in at the frame boundary, so a frame is
// never painted from two different values.
//
// Load handshake: load is a valid-only strobe with no ready (the controller
// can always accept). A cycle with load=1 copies valueIn into the shadow and
// marks it pending; later loads overwrite it. At the frame boundary a
// pending shadow moves into the display register and loadAck pulses in the
// same cycle as frameTick. A load on the boundary cycle itself lands after
// the swap and stays pending for the following frame.
//
// dbgState mirrors the scan FSM state (0 = BLANK, 1 = SHOW) for checkers.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] valueIn,
    input  logic                    lzSuppress,
    input  logic [NUM_DIGITS-1:0]   digitEn,
    output logic                    loadAck,
    output logic                    frameTick,
    output logic [NUM_DIGITS-1:0]   anodeN,
    output logic [6:0]              segN,
    output logic                    dbgState
);

    localparam int CW = cnt_width(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int VW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SLOT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST       = IW'(NUM_DIGITS - 1);

    // Scan sequencing state.
    scan_state_e       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              boundary;

    // Value buffering.
    logic [VW-1:0]     disp_q, disp_d;
    logic [VW-1:0]     shadow_q, shadow_d;
    logic              pend_q, pend_d;

    // Registered outputs and decoder feed.
    logic              tick_q, tick_d;
    logic              ack_q, ack_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic              blank_q, blank_d;
    logic [3:0]        nib_q, nib_d;
    logic [NUM_DIGITS-1:0] upper_zero;
    logic [6:0]        seg_dec;

    // All state and output registers; reset lands in digit 0 BLANK, dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_BLANK;
            cnt_q    <= '0;
            idx_q    <= '0;
            disp_q   <= '0;
            shadow_q <= '0;
            pend_q   <= 1'b0;
            tick_q   <= 1'b0;
            ack_q    <= 1'b0;
            anode_q  <= '1;
            blank_q  <= 1'b1;
            nib_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            disp_q   <= disp_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            tick_q   <= tick_d;
            ack_q    <= ack_d;
            anode_q  <= anode_d;
            blank_q  <= blank_d;
            nib_q    <= nib_d;
        end
    end

    // Slot sequencing: BLANK for BLANK_CYCLES, then SHOW until the slot ends.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        boundary = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == CNT_BLANK_LAST) begin
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (cnt_q == CNT_SLOT_LAST) begin
                    state_d  = ST_BLANK;
                    cnt_d    = '0;
                    idx_d    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    boundary = (idx_q == IDX_LAST);
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Shadow capture and frame-boundary swap; a same-cycle load wins over the clear.
    always_comb begin
        disp_d   = disp_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        ack_d    = 1'b0;
        tick_d   = boundary;
        if (boundary && pend_q) begin
            disp_d = shadow_q;
            pend_d = 1'b0;
            ack_d  = 1'b1;
        end
        if (load) begin
            shadow_d = valueIn;
            pend_d   = 1'b1;
        end
    end

    // upper_zero[k]: every display nibble from digit k up to the top is zero.
    always_comb begin
        upper_zero = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            for (int j = 0; j < NUM_DIGITS; j++) begin
                if (j >= k && disp_d[4*j +: 4] != 4'h0) begin
                    upper_zero[k] = 1'b0;
                end
            end
        end
    end

    // Next anode pattern, routed nibble and blank flag, aligned with next state.
    always_comb begin
        anode_d = '1;
        nib_d   = disp_d[4*idx_d +: 4];
        blank_d = 1'b1;
        if (state_d == ST_SHOW) begin
            anode_d[idx_d] = 1'b0;
            blank_d = !digitEn[idx_d] ||
                      (lzSuppress && (idx_d != '0) && upper_zero[idx_d]);
        end
    end

    seg_scan_ctrl_hex7seg u_dec (
        .nibble_i (nib_q),
        .seg_o    (seg_dec)
    );

    assign segN      = blank_q ? SEG_OFF : seg_dec;
    assign anodeN    = anode_q;
    assign frameTick = tick_q;
    assign loadAck   = ack_q;
    assign dbgState  = state_q;

endmodule
